// File: rtl/cr_lt_ctrl.sv
// cr_lt_ctrl: clock-recovery link-training sequencer for the DP source.
// It programs the PHY, writes TPS1 and the drive settings over AUX, waits
// the CR interval, and then reads the lane status. When a lane has not
// locked, it asks cr_err_chk for a decision and applies the returned
// drive, bandwidth or lane-count change.
// Optional feature: define CR_AUX_TIMEOUT_EN to enable the AUX ack watchdog.
// The watchdog retries a request twice, then fails on the third timeout.
module cr_lt_ctrl #(
  parameter int CR_WAIT_CYC = 400,
  parameter int CHK_TO_CYC  = 16,
  parameter int AUX_TO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lt_start,
  input  logic [7:0]  link_bw_in,
  input  logic [1:0]  link_lc_in,
  input  logic [1:0]  max_vtg_in,
  output logic        aux_req,
  output logic        aux_rd,
  input  logic        aux_ack,
  input  logic [23:0] aux_rd_data,
  output logic [7:0]  phy_bw,
  output logic [1:0]  phy_lc,
  output logic [7:0]  phy_vtg,
  output logic [7:0]  phy_pre,
  output logic        config_param_vld,
  output logic [7:0]  link_bw_cr,
  output logic [1:0]  link_lc_cr,
  output logic [1:0]  max_vtg,
  output logic        cr_chk_start,
  output logic [7:0]  adj_vtg,
  output logic [7:0]  adj_pre,
  output logic        cr_completed,
  output logic        fsm_cr_failed,
  input  logic [7:0]  new_bw_cr,
  input  logic [1:0]  new_lc_cr,
  input  logic        err_cr_failed,
  input  logic        drive_setting_flag,
  input  logic        bw_flag,
  input  logic        lc_flag,
  output logic        cr_done,
  output logic        cr_fail,
  output logic        busy
);

`ifdef CR_AUX_TIMEOUT_EN
  localparam bit AUX_WD_EN = 1'b1;
`else
  localparam bit AUX_WD_EN = 1'b0;
`endif

  localparam int IW = $clog2(CR_WAIT_CYC) + 1;
  localparam int CW = $clog2(CHK_TO_CYC) + 1;
  localparam int AW = $clog2(AUX_TO_CYC) + 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CONFIG    = 4'd1,
    S_WR_TP     = 4'd2,
    S_WAIT_INTV = 4'd3,
    S_RD_STS    = 4'd4,
    S_EVAL      = 4'd5,
    S_CHK_WAIT  = 4'd6,
    S_DONE      = 4'd7,
    S_FAIL      = 4'd8
  } state_t;

  state_t        state_r;
  logic [IW-1:0] intv_cnt_r;
  logic [CW-1:0] chk_cnt_r;
  logic [AW-1:0] aux_to_cnt_r;
  logic [1:0]    aux_retry_r;
  logic [3:0]    sts_done_r;

  logic          aux_ack_ok_s;
  logic          aux_to_hit_s;
  logic          is_rd_s;

  // The lanes that must report CR_DONE for the current lane count.
  function automatic logic [3:0] lane_mask(input logic [1:0] lc);
    case (lc)
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      2'b11:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0001;
    endcase
  endfunction

  // Qualify the AUX ack and detect a watchdog expiry on the pending request.
  always_comb begin
    aux_ack_ok_s = aux_req & aux_ack;
    aux_to_hit_s = AUX_WD_EN & aux_req & ~aux_ack &
                   (aux_to_cnt_r == AW'(AUX_TO_CYC - 1));
    is_rd_s      = (state_r == S_RD_STS);
  end

  // Training sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= S_IDLE;
      intv_cnt_r       <= '0;
      chk_cnt_r        <= '0;
      aux_to_cnt_r     <= '0;
      aux_retry_r      <= 2'd0;
      sts_done_r       <= 4'd0;
      aux_req          <= 1'b0;
      aux_rd           <= 1'b0;
      phy_bw           <= 8'd0;
      phy_lc           <= 2'd0;
      phy_vtg          <= 8'd0;
      phy_pre          <= 8'd0;
      config_param_vld <= 1'b0;
      link_bw_cr       <= 8'd0;
      link_lc_cr       <= 2'd0;
      max_vtg          <= 2'd0;
      cr_chk_start     <= 1'b0;
      adj_vtg          <= 8'd0;
      adj_pre          <= 8'd0;
      cr_completed     <= 1'b0;
      fsm_cr_failed    <= 1'b0;
      cr_done          <= 1'b0;
      cr_fail          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      // One-cycle strobes default low.
      config_param_vld <= 1'b0;
      cr_chk_start     <= 1'b0;
      cr_done          <= 1'b0;
      cr_completed     <= 1'b0;
      cr_fail          <= 1'b0;
      fsm_cr_failed    <= 1'b0;

      case (state_r)
        S_IDLE: begin
          if (lt_start) begin
            phy_bw       <= link_bw_in;
            phy_lc       <= link_lc_in;
            link_bw_cr   <= link_bw_in;
            link_lc_cr   <= link_lc_in;
            max_vtg      <= max_vtg_in;
            phy_vtg      <= 8'd0;
            phy_pre      <= 8'd0;
            aux_to_cnt_r <= '0;
            aux_retry_r  <= 2'd0;
            busy         <= 1'b1;
            state_r      <= S_CONFIG;
          end else begin
            state_r      <= S_IDLE;
          end
        end

        S_CONFIG: begin
          config_param_vld <= 1'b1;
          state_r          <= S_WR_TP;
        end

        S_WR_TP, S_RD_STS: begin
          if (aux_ack_ok_s) begin
            aux_req      <= 1'b0;
            aux_rd       <= 1'b0;
            aux_to_cnt_r <= '0;
            aux_retry_r  <= 2'd0;
            if (is_rd_s) begin
              sts_done_r <= aux_rd_data[3:0];
              adj_vtg    <= aux_rd_data[15:8];
              adj_pre    <= aux_rd_data[23:16];
              state_r    <= S_EVAL;
            end else begin
              intv_cnt_r <= '0;
              state_r    <= S_WAIT_INTV;
            end
          end else if (aux_to_hit_s) begin
            // Drop the request for one cycle; the next cycle reissues it.
            aux_req      <= 1'b0;
            aux_to_cnt_r <= '0;
            if (aux_retry_r == 2'd2) begin
              aux_retry_r <= 2'd0;
              aux_rd      <= 1'b0;
              state_r     <= S_FAIL;
            end else begin
              aux_retry_r <= aux_retry_r + 2'd1;
            end
          end else begin
            aux_req <= 1'b1;
            aux_rd  <= is_rd_s;
            if (AUX_WD_EN && aux_req) begin
              aux_to_cnt_r <= aux_to_cnt_r + AW'(1);
            end else begin
              aux_to_cnt_r <= aux_to_cnt_r;
            end
          end
        end

        S_WAIT_INTV: begin
          if (intv_cnt_r == IW'(CR_WAIT_CYC - 1)) begin
            // Raise the read request on the transition so it lands on time.
            aux_req      <= 1'b1;
            aux_rd       <= 1'b1;
            aux_to_cnt_r <= '0;
            state_r      <= S_RD_STS;
          end else begin
            intv_cnt_r   <= intv_cnt_r + IW'(1);
          end
        end

        S_EVAL: begin
          if ((sts_done_r & lane_mask(phy_lc)) == lane_mask(phy_lc)) begin
            state_r      <= S_DONE;
          end else begin
            cr_chk_start <= 1'b1;
            chk_cnt_r    <= '0;
            state_r      <= S_CHK_WAIT;
          end
        end

        S_CHK_WAIT: begin
          if (err_cr_failed) begin
            state_r <= S_FAIL;
          end else if (lc_flag) begin
            phy_lc  <= new_lc_cr;
            phy_bw  <= new_bw_cr;
            phy_vtg <= 8'd0;
            phy_pre <= 8'd0;
            state_r <= S_WR_TP;
          end else if (bw_flag) begin
            phy_bw  <= new_bw_cr;
            phy_vtg <= 8'd0;
            phy_pre <= 8'd0;
            state_r <= S_WR_TP;
          end else if (drive_setting_flag) begin
            phy_vtg <= adj_vtg;
            phy_pre <= adj_pre;
            state_r <= S_WR_TP;
          end else if (chk_cnt_r == CW'(CHK_TO_CYC - 1)) begin
            state_r <= S_FAIL;
          end else begin
            chk_cnt_r <= chk_cnt_r + CW'(1);
          end
        end

        S_DONE: begin
          cr_done      <= 1'b1;
          cr_completed <= 1'b1;
          busy         <= 1'b0;
          state_r      <= S_IDLE;
        end

        S_FAIL: begin
          cr_fail       <= 1'b1;
          fsm_cr_failed <= 1'b1;
          aux_req       <= 1'b0;
          aux_rd        <= 1'b0;
          busy          <= 1'b0;
          state_r       <= S_IDLE;
        end

        default: begin
          aux_req <= 1'b0;
          aux_rd  <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
